xilinx_clock_ctrl: RTL and testbench

Sequencer in front of xilinx_clock. It accepts CLKSET-style clock-config writes from the hub and sequences MMCM reset and lock qualification. It applies each new 7-bit config to the clock generator only while the MMCM is locked, then holds it stable long enough for the BUFGMUX chain to finish switching (worst case RCSLOW, ~51 us). It runs on the free-running clock_160 and provides the single point of control over the cfg input of xilinx_clock.

---
 rtl/xilinx_clock_pkg.sv | 28 ++
 rtl/xilinx_clock_ctrl_sync2.sv | 22 ++
 rtl/xilinx_clock_ctrl.sv | 102 ++++++++++
 tb/tb_xilinx_clock_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_clock_pkg.sv
// Shared types and constants for the xilinx_clock config sequencer.
// Config layout: {PLLENA,OSCENA,OSCM1,OSCM0,CLKSEL[2:0]}.
package xilinx_clock_pkg;

  typedef enum logic [1:0] {
    STARTUP,
    WAIT_LOCK,
    IDLE,
    HOLD
  } state_t;

  localparam int PLLENA    = 6;
  localparam int OSCENA    = 5;
  localparam int CLKSEL_HI = 2;
  localparam int CLKSEL_LO = 0;

  localparam logic [6:0] CFG_RCFAST = 7'h00;

  typedef struct packed {
    logic       valid;
    logic [6:0] cfg;
  } pend_t;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (&v) ? v : v + 17'd1;
  endfunction

endpackage

// File: rtl/xilinx_clock_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
// Output reads 0 while reset is asserted.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/xilinx_clock_ctrl.sv
// MMCM reset/lock sequencer and single point of control for the
// xilinx_clock cfg input; new configs are applied only while locked.
module xilinx_clock_ctrl
  import xilinx_clock_pkg::*;
#(
  parameter int         RST_CYCLES   = 32,
  parameter int         LOCK_TIMEOUT = 65536,
  parameter int         HOLD_CYCLES  = 16384,
  parameter logic [6:0] CFG_RESET    = CFG_RCFAST
) (
  input  logic       clock_160,
  input  logic       nres,
  input  logic [6:0] cfg_in,
  input  logic       cfg_wr,
  input  logic       mmcm_locked,
  output logic [6:0] cfg_out,
  output logic       mmcm_rst,
  output logic       cfg_ack,
  output logic       busy,
  output logic       lock_err
);

  localparam logic [16:0] RST_LAST  = 17'(RST_CYCLES - 1);
  localparam logic [16:0] TO_LAST   = 17'(LOCK_TIMEOUT - 1);
  localparam logic [16:0] HOLD_LAST = 17'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_d;
  logic [16:0] cnt;
  pend_t       pend;
  logic        lk_s;
  logic        consume;
  logic        lose;
  logic        timeout;

  sync2 u_lock_sync (
    .clk  (clock_160),
    .rst_n(nres),
    .d    (mmcm_locked),
    .q    (lk_s)
  );

  // Counter restarts on every state change and saturates otherwise.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      state <= STARTUP;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? '0 : sat_inc(cnt);
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      STARTUP: begin
        if (cnt >= RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk_s)                state_d = IDLE;
        else if (cnt >= TO_LAST) state_d = STARTUP;
      end
      IDLE: begin
        if (!lk_s)
          state_d = WAIT_LOCK;
        else if (pend.valid && pend.cfg != cfg_out)
          state_d = HOLD;
      end
      HOLD: begin
        if (!lk_s)                 state_d = WAIT_LOCK;
        else if (cnt >= HOLD_LAST) state_d = IDLE;
      end
      default: state_d = STARTUP;
    endcase
  end

  always_comb begin
    mmcm_rst = (state == STARTUP);
    busy     = (state != IDLE) | pend.valid;
    consume  = (state == IDLE) & lk_s & pend.valid;
    lose     = ((state == IDLE) | (state == HOLD)) & ~lk_s;
    timeout  = (state == WAIT_LOCK) & ~lk_s & (cnt >= TO_LAST);
  end

  // A write landing on the consume edge reloads pending for the next pass.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      pend     <= '0;
      cfg_out  <= CFG_RESET;
      cfg_ack  <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      if (cfg_wr)       pend <= '{valid: 1'b1, cfg: cfg_in};
      else if (consume) pend.valid <= 1'b0;
      if (consume) cfg_out <= pend.cfg;
      cfg_ack  <= consume;
      lock_err <= lock_err | lose | timeout;
    end
  end

endmodule

// File: tb/tb_xilinx_clock_ctrl.sv
// Scoreboard bench for xilinx_clock_ctrl with shortened timing params.
// Expected acks are queued at write time and checked by a monitor.
module tb_xilinx_clock_ctrl;

  localparam int RSTC  = 4;
  localparam int TO    = 64;
  localparam int HOLDC = 8;

  logic       clock_160 = 1'b0;
  logic       nres = 1'b0;
  logic [6:0] cfg_in = 7'h00;
  logic       cfg_wr = 1'b0;
  logic       mmcm_locked = 1'b1;
  logic [6:0] cfg_out;
  logic       mmcm_rst;
  logic       cfg_ack;
  logic       busy;
  logic       lock_err;

  xilinx_clock_ctrl #(
    .RST_CYCLES  (RSTC),
    .LOCK_TIMEOUT(TO),
    .HOLD_CYCLES (HOLDC),
    .CFG_RESET   (7'h00)
  ) dut (
    .clock_160  (clock_160),
    .nres       (nres),
    .cfg_in     (cfg_in),
    .cfg_wr     (cfg_wr),
    .mmcm_locked(mmcm_locked),
    .cfg_out    (cfg_out),
    .mmcm_rst   (mmcm_rst),
    .cfg_ack    (cfg_ack),
    .busy       (busy),
    .lock_err   (lock_err)
  );

  always #5 clock_160 = ~clock_160;

  typedef struct packed {
    logic [6:0] cfg;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_ack  = 0;
  int   n_push = 0;
  bit   saw6e  = 1'b0;

  function automatic void check(input string name, input int act,
                                input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Monitor: every cfg_ack pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_160);
      if (nres) begin
        if (cfg_out == 7'h6E) saw6e = 1'b1;
        if (cfg_ack) begin
          n_ack++;
          if (sb.size() == 0) begin
            check("ack_expected", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("ack_cfg_out", cfg_out, e.cfg);
            check("ack_busy", busy, e.busy);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock_160);
    #1;
  endtask

  task automatic wr(input logic [6:0] v);
    cfg_in = v;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic wr_exp(input logic [6:0] v, input logic b);
    sb.push_back('{cfg: v, busy: b});
    n_push++;
    wr(v);
  endtask

  task automatic wait_ack(input string name, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clock_160);
      if (cfg_ack) break;
    end
    check({name, "_ack_seen"}, int'(k < bound), 1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clock_160);
      if (!busy) break;
    end
    check({name, "_idle_seen"}, int'(k < bound), 1);
  endtask

  initial begin
    int c;
    // Reset values
    #2;
    check("rst_cfg_out", cfg_out, 7'h00);
    check("rst_mmcm_rst", mmcm_rst, 1);
    check("rst_cfg_ack", cfg_ack, 0);
    check("rst_busy", busy, 1);
    check("rst_lock_err", lock_err, 0);
    tick();
    nres = 1'b1;

    c = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_160);
      if (mmcm_rst) c++;
      else break;
    end
    check("startup_rst_cycles", c, RSTC);
    wait_idle("startup", 20);
    check("idle_cfg_out", cfg_out, 7'h00);
    check("idle_lock_err", lock_err, 0);

    // Simple apply and HOLD length
    tick();
    wr_exp(7'h6F, 1'b1);
    wait_ack("w6f", 10);
    c = busy ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock_160);
      if (busy) c++;
      else break;
    end
    check("hold_busy_cycles", c, HOLDC);

    // Writes during HOLD collapse to the last one
    tick();
    wr_exp(7'h10, 1'b1);
    wait_ack("w10", 10);
    tick();
    wr(7'h6E);
    wr_exp(7'h6D, 1'b1);
    check("hold_cfg_frozen", cfg_out, 7'h10);
    check("hold_busy", busy, 1);
    wait_ack("w6d", 20);
    wait_idle("w6d", 30);
    check("after_w6d_cfg", cfg_out, 7'h6D);

    // Same value: ack without HOLD
    tick();
    wr_exp(7'h6D, 1'b0);
    wait_ack("same", 10);
    repeat (3) @(negedge clock_160);
    check("same_busy", busy, 0);
    check("same_cfg", cfg_out, 7'h6D);

    // Async reset mid-HOLD, then lock timeout
    tick();
    wr_exp(7'h55, 1'b1);
    wait_ack("w55", 10);
    nres = 1'b0;
    mmcm_locked = 1'b0;
    #1;
    check("midhold_rst_cfg", cfg_out, 7'h00);
    check("midhold_rst_mmcm", mmcm_rst, 1);
    check("midhold_rst_ack", cfg_ack, 0);
    check("midhold_rst_busy", busy, 1);
    tick();
    nres = 1'b1;
    c = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock_160);
      if (lock_err) break;
      c++;
    end
    check("timeout_cycles", c, RSTC + TO);
    c = mmcm_rst ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_160);
      if (mmcm_rst) c++;
      else break;
    end
    check("rerst_cycles", c, RSTC);
    mmcm_locked = 1'b1;
    wait_idle("relock_to", 20);
    check("sticky_lock_err", lock_err, 1);
    check("relock_to_cfg", cfg_out, 7'h00);

    // Lock loss with a write in flight
    nres = 1'b0;
    #2;
    check("rst_clears_err", lock_err, 0);
    tick();
    nres = 1'b1;
    wait_idle("startup2", 20);
    tick();
    mmcm_locked = 1'b0;
    tick();
    wr_exp(7'h2A, 1'b1);
    repeat (8) @(negedge clock_160);
    check("loss_lock_err", lock_err, 1);
    check("loss_busy", busy, 1);
    check("loss_cfg_frozen", cfg_out, 7'h00);
    check("loss_mmcm_rst", mmcm_rst, 0);
    mmcm_locked = 1'b1;
    wait_ack("relock", 20);
    wait_idle("relock", 30);
    check("relock_cfg", cfg_out, 7'h2A);

    repeat (3) @(negedge clock_160);
    check("sb_empty", sb.size(), 0);
    check("ack_count", n_ack, n_push);
    check("never_6e", saw6e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
